sti_rx_dac: RTL



---
 rtl/sti_pkg.sv | 38 +++
 rtl/sti_rx_shifter.sv | 80 ++++++++
 rtl/sti_rx_dac.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/sti_pkg.sv
// Shared constants and helpers for the STI serial receiver.
package sti_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned BYTE_W = 3;

  localparam logic [1:0] LEN8  = 2'b00;
  localparam logic [1:0] LEN16 = 2'b01;
  localparam logic [1:0] LEN24 = 2'b10;
  localparam logic [1:0] LEN32 = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SHIFT = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_FILL  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Frame length code to serial bit count.
  function automatic logic [CNT_W-1:0] len_bits(input logic [1:0] len);
    logic [CNT_W-1:0] n;
    n = CNT_W'(32);
    case (len)
      LEN8:    n = CNT_W'(8);
      LEN16:   n = CNT_W'(16);
      LEN24:   n = CNT_W'(24);
      LEN32:   n = CNT_W'(32);
      default: n = CNT_W'(32);
    endcase
    return n;
  endfunction

  // Frame length code to byte count.
  function automatic logic [BYTE_W-1:0] len_bytes(input logic [1:0] len);
    return BYTE_W'(len) + BYTE_W'(1);
  endfunction

endpackage

// File: rtl/sti_rx_shifter.sv
// Serial bit collector: counts bits, places each by the captured order and
// flags frame completion or a premature strobe drop.
module sti_rx_shifter
  import sti_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              shift_i,
  input  logic              si_data,
  input  logic              si_valid,
  input  logic [1:0]        cfg_length,
  input  logic              cfg_msb,
  output logic [WORD_W-1:0] word_c,
  output logic [1:0]        len_o,
  output logic              frame_done_c,
  output logic              abort_c
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        len_q, len_d;
  logic              msb_q, msb_d;

  logic [1:0]        len_sel;
  logic              msb_sel;
  logic [WORD_W-1:0] base;
  logic [CNT_W-1:0]  k;
  logic [CNT_W-1:0]  nbits;
  logic [CNT_W-1:0]  pos;

  // The first bit uses the live config; later bits use the captured one.
  always_comb begin
    len_sel      = start_i ? cfg_length : len_q;
    msb_sel      = start_i ? cfg_msb : msb_q;
    base         = start_i ? '0 : word_q;
    k            = start_i ? '0 : cnt_q;
    nbits        = len_bits(len_sel);
    pos          = msb_sel ? (nbits - CNT_W'(1) - k) : k;
    word_c       = base | (WORD_W'(si_data) << pos);
    frame_done_c = shift_i && si_valid && (cnt_q == nbits - CNT_W'(1));
    abort_c      = shift_i && !si_valid;

    word_d = word_q;
    cnt_d  = cnt_q;
    len_d  = len_q;
    msb_d  = msb_q;
    if (start_i) begin
      word_d = word_c;
      cnt_d  = CNT_W'(1);
      len_d  = cfg_length;
      msb_d  = cfg_msb;
    end else if (shift_i) begin
      if (si_valid && !frame_done_c) begin
        word_d = word_c;
        cnt_d  = cnt_q + CNT_W'(1);
      end else begin
        word_d = '0;
        cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
      msb_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      msb_q  <= msb_d;
    end
  end

  assign len_o = len_q;

endmodule

// File: rtl/sti_rx_dac.sv
// STI receiver top: frame FSM, MSB-first byte writer into pixel memory,
// end-of-stream zero fill and sticky finish.
module sti_rx_dac
  import sti_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned LAST_ADDR = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              si_data,
  input  logic              si_valid,
  input  logic [1:0]        cfg_length,
  input  logic              cfg_msb,
  input  logic              si_end,
  output logic [WORD_W-1:0] po_data,
  output logic              po_valid,
  output logic              pixel_wr,
  output logic [ADDR_W-1:0] pixel_addr,
  output logic [7:0]        pixel_dataout,
  output logic              pixel_finish,
  output logic              rx_err
);

  logic [2:0]        state_q, state_d;
  logic [WORD_W-1:0] po_data_q, po_data_d;
  logic              po_valid_q, po_valid_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dout_q, dout_d;
  logic              finish_q, finish_d;
  logic              err_q, err_d;
  logic [BYTE_W-1:0] bidx_q, bidx_d;

  logic              start_c, shift_c, last_addr_c;
  logic [WORD_W-1:0] word_c;
  logic [1:0]        shf_len;
  logic              frame_done_c, abort_c;

  assign start_c     = (state_q == ST_IDLE) && si_valid && !si_end;
  assign shift_c     = (state_q == ST_SHIFT);
  assign last_addr_c = (addr_q == ADDR_W'(LAST_ADDR));

  sti_rx_shifter u_shifter (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start_c),
    .shift_i      (shift_c),
    .si_data      (si_data),
    .si_valid     (si_valid),
    .cfg_length   (cfg_length),
    .cfg_msb      (cfg_msb),
    .word_c       (word_c),
    .len_o        (shf_len),
    .frame_done_c (frame_done_c),
    .abort_c      (abort_c)
  );

  // Next state; outputs are staged so each write is visible in its own cycle.
  always_comb begin
    state_d    = state_q;
    po_data_d  = po_data_q;
    po_valid_d = 1'b0;
    wr_d       = 1'b0;
    addr_d     = addr_q;
    dout_d     = dout_q;
    finish_d   = finish_q;
    err_d      = 1'b0;
    bidx_d     = bidx_q;

    case (state_q)
      ST_IDLE: begin
        if (si_end) begin
          state_d = ST_FILL;
          wr_d    = 1'b1;
          dout_d  = '0;
        end else if (si_valid) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort_c) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (frame_done_c) begin
          po_valid_d = 1'b1;
          po_data_d  = word_c;
          wr_d       = 1'b1;
          bidx_d     = len_bytes(shf_len) - BYTE_W'(1);
          dout_d     = 8'(word_c >> {bidx_d, 3'b000});
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        err_d  = si_valid;
        addr_d = addr_q + ADDR_W'(1);
        if (last_addr_c) begin
          state_d  = ST_DONE;
          finish_d = 1'b1;
        end else if (bidx_q != '0) begin
          wr_d   = 1'b1;
          bidx_d = bidx_q - BYTE_W'(1);
          dout_d = 8'(po_data_q >> {bidx_d, 3'b000});
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        addr_d = addr_q + ADDR_W'(1);
        if (last_addr_c) begin
          state_d  = ST_DONE;
          finish_d = 1'b1;
        end else begin
          wr_d = 1'b1;
        end
      end
      ST_DONE: begin
        err_d = si_valid;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      po_data_q  <= '0;
      po_valid_q <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      dout_q     <= '0;
      finish_q   <= 1'b0;
      err_q      <= 1'b0;
      bidx_q     <= '0;
    end else begin
      state_q    <= state_d;
      po_data_q  <= po_data_d;
      po_valid_q <= po_valid_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      finish_q   <= finish_d;
      err_q      <= err_d;
      bidx_q     <= bidx_d;
    end
  end

  assign po_data       = po_data_q;
  assign po_valid      = po_valid_q;
  assign pixel_wr      = wr_q;
  assign pixel_addr    = addr_q;
  assign pixel_dataout = dout_q;
  assign pixel_finish  = finish_q;
  assign rx_err        = err_q;

endmodule
